// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the button debouncer: FSM state encodings and the
// default qualification window derived from the board clock.
package button_debouncer_pkg;

    localparam int BOARD_CLK_HZ = 100_000_000;
    localparam int DEBOUNCE_MS  = 10;

    function automatic int ms_to_cycles(input int ms);
        return (BOARD_CLK_HZ / 1000) * ms;
    endfunction

    localparam int DEFAULT_STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS);

    typedef enum logic [1:0] {
        DB_IDLE_LOW  = 2'd0,
        DB_WAIT_HIGH = 2'd1,
        DB_IDLE_HIGH = 2'd2,
        DB_WAIT_LOW  = 2'd3
    } db_state_t;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs, reset to 0.
// Latency: 2 clk cycles. Backpressure: none, samples every cycle.
// Input is assumed asynchronous to clk, so only q is safe to consume.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one raw mechanical input into a clean registered level plus busy flag.
// Latency: STABLE_CYCLES+2 cycles with BUTTON_DEBOUNCER_SYNC_EN, STABLE_CYCLES without.
// Backpressure: none; raw input is sampled every cycle.
module button_debouncer
    import button_debouncer_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic signal_raw,
    output logic signal_clean,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    db_state_t        state;
    db_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             clean_nxt;
    logic             busy_nxt;

`ifdef BUTTON_DEBOUNCER_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (signal_raw),
        .q   (s)
    );
`else
    // Bypass only for sources already synchronous to clk.
    assign s = signal_raw;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= DB_IDLE_LOW;
            cnt          <= '0;
            signal_clean <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            signal_clean <= clean_nxt;
            busy         <= busy_nxt;
        end
    end

    // cnt holds the number of consecutive samples already seen at the candidate level.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        case (state)
            DB_IDLE_LOW: begin
                if (s) begin
                    state_nxt = DB_WAIT_HIGH;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_WAIT_HIGH: begin
                if (!s) begin
                    state_nxt = DB_IDLE_LOW;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = DB_IDLE_HIGH;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            DB_IDLE_HIGH: begin
                if (!s) begin
                    state_nxt = DB_WAIT_LOW;
                    cnt_nxt   = CNT_ONE;
                end
            end
            DB_WAIT_LOW: begin
                if (s) begin
                    state_nxt = DB_IDLE_HIGH;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = DB_IDLE_LOW;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                state_nxt = DB_IDLE_LOW;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        clean_nxt = (state_nxt == DB_IDLE_HIGH) || (state_nxt == DB_WAIT_LOW);
        busy_nxt  = (state_nxt == DB_WAIT_HIGH) || (state_nxt == DB_WAIT_LOW);
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with STABLE_CYCLES=4, either build.
module tb_button_debouncer;

    localparam int STABLE = 4;
`ifdef BUTTON_DEBOUNCER_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif
    localparam int LAT = STABLE + SL;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic signal_raw = 1'b0;
    logic signal_clean;
    logic busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: run length of consecutive samples differing from the clean level.
    logic m_clean = 1'b0;
    int   m_run   = 0;
    logic m_p0    = 1'b0;
    logic m_p1    = 1'b0;

    always #5 clk = ~clk;

    button_debouncer #(.STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .signal_raw   (signal_raw),
        .signal_clean (signal_clean),
        .busy         (busy)
    );

    task automatic model_edge();
        logic s;
        if (rst) begin
            m_clean = 1'b0;
            m_run   = 0;
            m_p0    = 1'b0;
            m_p1    = 1'b0;
        end else begin
            s    = (SL == 2) ? m_p1 : signal_raw;
            m_p1 = m_p0;
            m_p0 = signal_raw;
            if (s != m_clean) begin
                m_run++;
                if (m_run == STABLE) begin
                    m_clean = s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
        end
    endtask

    // Drive one cycle: inputs set after a negedge, model stepped at posedge, return at negedge.
    task automatic cyc(input logic r, input logic rs);
        signal_raw = r;
        rst        = rs;
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1'b0, 1'b1);
            n_checks++;
            if (signal_clean !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_vals clean=%b busy=%b expected 0 0", signal_clean, busy);
            end
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0);
            n_checks++;
            if (signal_clean !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL idle_low cyc=%0d clean=%b busy=%b expected 0 0", i, signal_clean, busy);
            end
        end
    endtask

    task automatic test_step();
        for (int k = 1; k <= LAT + 3; k++) begin
            logic exp_clean;
            logic exp_busy;
            cyc(1'b1, 1'b0);
            exp_clean = (k >= LAT);
            exp_busy  = (k >= SL + 1) && (k < LAT);
            n_checks++;
            if (signal_clean !== exp_clean) begin
                n_fail++;
                $display("FAIL step_clean k=%0d got %b expected %b", k, signal_clean, exp_clean);
            end
            n_checks++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL step_busy k=%0d got %b expected %b", k, busy, exp_busy);
            end
        end
        for (int k = 1; k <= LAT + 3; k++) begin
            cyc(1'b0, 1'b0);
            n_checks++;
            if (signal_clean !== m_clean || busy !== m_busy()) begin
                n_fail++;
                $display("FAIL step_fall k=%0d got %b/%b expected %b/%b", k, signal_clean, busy, m_clean, m_busy());
            end
        end
    endtask

    function automatic logic m_busy();
        return m_run != 0;
    endfunction

    task automatic test_bounce();
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic prev   = signal_clean;
        int   rises  = 0;
        for (int k = 0; k < 5 + LAT + 3; k++) begin
            cyc((k < 5) ? pat[k] : 1'b1, 1'b0);
            if (signal_clean === 1'b1 && prev === 1'b0) rises++;
            prev = signal_clean;
            n_checks++;
            if (signal_clean !== m_clean || busy !== m_busy()) begin
                n_fail++;
                $display("FAIL bounce k=%0d got %b/%b expected %b/%b", k, signal_clean, busy, m_clean, m_busy());
            end
            if (k < 5 + LAT - 1) begin
                n_checks++;
                if (signal_clean !== 1'b0) begin
                    n_fail++;
                    $display("FAIL bounce_early k=%0d got %b expected 0", k, signal_clean);
                end
            end
        end
        n_checks++;
        if (rises != 1) begin
            n_fail++;
            $display("FAIL bounce_rises got %0d expected 1", rises);
        end
    endtask

    task automatic test_release();
        int fall_at = 3 + SL + STABLE;
        for (int e = 1; e <= fall_at + 3; e++) begin
            logic r;
            logic exp_clean;
            r = (e == 3);
            cyc(r, 1'b0);
            exp_clean = (e < fall_at);
            n_checks++;
            if (signal_clean !== exp_clean) begin
                n_fail++;
                $display("FAIL release e=%0d got %b expected %b", e, signal_clean, exp_clean);
            end
            n_checks++;
            if (signal_clean !== m_clean || busy !== m_busy()) begin
                n_fail++;
                $display("FAIL release_model e=%0d got %b/%b expected %b/%b", e, signal_clean, busy, m_clean, m_busy());
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < SL + 2; k++) cyc(1'b1, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || signal_clean !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_wait busy=%b clean=%b expected 1 0", busy, signal_clean);
        end
        cyc(1'b1, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || signal_clean !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset busy=%b clean=%b expected 0 0", busy, signal_clean);
        end
        for (int k = 1; k <= LAT + 2; k++) begin
            logic exp_clean;
            cyc(1'b1, 1'b0);
            exp_clean = (k >= LAT);
            n_checks++;
            if (signal_clean !== exp_clean) begin
                n_fail++;
                $display("FAIL mid_requal k=%0d got %b expected %b", k, signal_clean, exp_clean);
            end
        end
    endtask

    task automatic test_random();
        logic r = 1'b0;
        int   run = 0;
        for (int i = 0; i < 3000; i++) begin
            logic rs;
            if (run == 0) begin
                r   = ~r;
                run = $urandom_range(1, 7);
            end
            run--;
            rs = ($urandom_range(0, 199) == 0);
            cyc(r, rs);
            n_checks++;
            if (signal_clean !== m_clean || busy !== m_busy()) begin
                n_fail++;
                $display("FAIL random i=%0d got %b/%b expected %b/%b", i, signal_clean, busy, m_clean, m_busy());
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_step();
        test_bounce();
        test_release();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw mechanical input (push-button or slide switch) into a clean, glitch-free level for the slot machine's control path. Sits directly upstream of `pos_edge_detect`. Its `signal_clean` output drives that block's `signal` input, so one physical press yields exactly one single-cycle `pulse`. One instance per physical input.

## Interface
- `STABLE_CYCLES`, default 1_000_000: consecutive synchronized samples at a new level required before `signal_clean` follows (10 ms at 100 MHz). Legal minimum is 2.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: counter width. It is derived and is never overridden by hand.
- `clk` input 1: single system clock. All logic is on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `signal_raw` input 1: asynchronous raw input from the pin.
- `signal_clean` output 1: debounced level, registered. Feeds `pos_edge_detect.signal`.
- `busy` output 1: high while a candidate level change is being qualified (WAIT states), registered.

## Operation
- Input stage: `signal_raw` → 2-FF synchronizer → `s` (see Configuration).
- FSM states: IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW. A 2-bit state register, plus `cnt[CNT_W-1:0]`.
- IDLE_LOW:
  - `s`=1 → WAIT_HIGH, `cnt`←1.
  - Otherwise hold, `cnt`←0.
- WAIT_HIGH:
  - `s`=1 and `cnt`==STABLE_CYCLES-1 → IDLE_HIGH, `signal_clean`←1, `cnt`←0.
  - `s`=1 otherwise → `cnt`←`cnt`+1.
  - `s`=0 → IDLE_LOW, `cnt`←0 (bounce rejected, no output change).
- IDLE_HIGH / WAIT_LOW: mirror image with polarities inverted. Commit sets `signal_clean`←0.
- `busy` = 1 exactly in WAIT_HIGH and WAIT_LOW.
- `cnt` never exceeds STABLE_CYCLES-1, so there is no wrap-around. The counter saturates by construction of the transition.
- `signal_clean` changes only on a commit transition. It never toggles on a sample run shorter than STABLE_CYCLES.

## Timing
- Reset values: `signal_clean`=0, `busy`=0, state IDLE_LOW, `cnt`=0, synchronizer flops 0.
- Reset has priority over every transition in the same cycle.
- Qualification: `s` must sit at the new level for STABLE_CYCLES consecutive rising edges. `signal_clean` updates on the edge that samples the STABLE_CYCLES-th such value.
- Latency from a clean `signal_raw` step to `signal_clean`:
  - With synchronizer: STABLE_CYCLES+2 cycles.
  - Without synchronizer: STABLE_CYCLES cycles.
- `busy` rises on the same edge WAIT is entered, one cycle after `s` first differs from `signal_clean`. It falls on the commit edge or the reject edge.
- Bounce during WAIT: a single opposite-level sample returns the FSM to IDLE and clears `cnt`. Qualification restarts from zero on the next differing sample.
- Reset mid-qualification: the candidate is abandoned and `signal_clean` is forced to 0.
  - If the input is held high through and after reset release, it re-qualifies after STABLE_CYCLES+2 cycles.
  - Downstream then sees one rising edge. This is intended.
- Minimum spacing between two `signal_clean` transitions is STABLE_CYCLES cycles.

## Configuration
- `BUTTON_DEBOUNCER_SYNC_EN`:
  - Defined (default in the top-level build): the 2-FF synchronizer is instantiated, and latency is as above.
  - Undefined: `s` = `signal_raw` directly, with no synchronizer flops and 2 cycles less latency. Only for inputs already synchronous to `clk` (simulation, or internally generated signals).
- FSM behaviour is identical in both builds.

## Structure
- Shared defs package/header holds:
  - FSM state encodings (`DB_IDLE_LOW`=2'd0, `DB_WAIT_HIGH`=2'd1, `DB_IDLE_HIGH`=2'd2, `DB_WAIT_LOW`=2'd3).
  - Default `STABLE_CYCLES` derived from the board clock frequency constant.
- One sub-module, `sync_2ff`: two back-to-back flops with synchronous active-high reset to 0. It is also reused for other asynchronous inputs.
- FSM and counter stay in `button_debouncer`.

## Test plan
Run with STABLE_CYCLES=4, sync enabled, unless noted.
- After reset, `signal_raw`=0 held → `signal_clean`=0 and `busy`=0 throughout.
- Clean step of `signal_raw` 0→1 held → `busy`=1 from cycle 3. `signal_clean`=1 exactly 6 cycles after the step, `busy`=0 the same cycle.
- Bounce: `signal_raw` 1,0,1,1,0 then solid 1 → `signal_clean` stays 0 until 4 consecutive high samples. It rises exactly once, and the downstream `pos_edge_detect` emits a single pulse.
- Release: from `signal_clean`=1, `signal_raw` 1→0 with one 1-cycle glitch high in WAIT_LOW → `cnt` restarts. `signal_clean` falls 4 cycles after the last glitch sample reaches `s`.
- Reset asserted mid-WAIT_HIGH (`cnt`=2) with input held high → `signal_clean`=0 and `busy`=0 on the reset edge. `signal_clean` rises 6 cycles after reset deassert.
- Build without `BUTTON_DEBOUNCER_SYNC_EN`, clean 0→1 step → `signal_clean` rises after exactly 4 cycles.
